// File: rtl/reg_file.sv
// ============================================================================
// Module      : reg_file
// Description : Architectural register file with per-register ROB rename tags,
//               commit write port, commit bypass on lookup and flush of tags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file #(
   parameter int REG_COUNT = 32,
   parameter int XLEN      = 32,
   parameter int ROB_ID_W  = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                rdy,
   input  logic                reset_from_rob_bus,
   input  logic [4:0]          rs1_from_issuer,
   input  logic [4:0]          rs2_from_issuer,
   output logic [ROB_ID_W-1:0] qj_to_issuer,
   output logic [XLEN-1:0]     vj_to_issuer,
   output logic [ROB_ID_W-1:0] qk_to_issuer,
   output logic [XLEN-1:0]     vk_to_issuer,
   input  logic                rename_valid_from_issuer,
   input  logic [4:0]          rd_from_issuer,
   input  logic [ROB_ID_W-1:0] dest_from_issuer,
   input  logic [ROB_ID_W-1:0] dest_from_rob,
   input  logic [4:0]          rd_from_rob,
   input  logic [XLEN-1:0]     value_from_rob
);

   logic [XLEN-1:0]     r_value [REG_COUNT];
   logic [ROB_ID_W-1:0] r_tag   [REG_COUNT];

   logic w_commit;
   logic w_rename;
   assign w_commit = (dest_from_rob != '0);
   assign w_rename = rename_valid_from_issuer && (rd_from_issuer != 5'd0);

   // Sources are read before same-cycle renames; a matching commit is bypassed.
   always_comb begin
      qj_to_issuer = '0;
      vj_to_issuer = '0;
      if (rst && (rs1_from_issuer != 5'd0)) begin
         if (r_tag[rs1_from_issuer] == '0) begin
            vj_to_issuer = r_value[rs1_from_issuer];
         end else if (w_commit && (rd_from_rob == rs1_from_issuer) &&
                      (dest_from_rob == r_tag[rs1_from_issuer])) begin
            vj_to_issuer = value_from_rob;
         end else begin
            qj_to_issuer = r_tag[rs1_from_issuer];
            vj_to_issuer = r_value[rs1_from_issuer];
         end
      end
   end

   always_comb begin
      qk_to_issuer = '0;
      vk_to_issuer = '0;
      if (rst && (rs2_from_issuer != 5'd0)) begin
         if (r_tag[rs2_from_issuer] == '0) begin
            vk_to_issuer = r_value[rs2_from_issuer];
         end else if (w_commit && (rd_from_rob == rs2_from_issuer) &&
                      (dest_from_rob == r_tag[rs2_from_issuer])) begin
            vk_to_issuer = value_from_rob;
         end else begin
            qk_to_issuer = r_tag[rs2_from_issuer];
            vk_to_issuer = r_value[rs2_from_issuer];
         end
      end
   end

   // Entry 0 is never written, so x0 stays zero with no producer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < REG_COUNT; i++) begin
            r_value[i] <= '0;
            r_tag[i]   <= '0;
         end
      end else if (rdy) begin
         for (int i = 1; i < REG_COUNT; i++) begin
            if (w_commit && (rd_from_rob == i[4:0])) begin
               r_value[i] <= value_from_rob;
            end
            if (reset_from_rob_bus) begin
               r_tag[i] <= '0;
            end else if (w_rename && (rd_from_issuer == i[4:0])) begin
               r_tag[i] <= dest_from_issuer;
            end else if (w_commit && (rd_from_rob == i[4:0]) &&
                         (r_tag[i] == dest_from_rob)) begin
               r_tag[i] <= '0;
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_reg_file.sv
// ============================================================================
// Module      : tb_reg_file
// Description : Directed self-checking bench for reg_file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_file;

   logic        clk;
   logic        rst;
   logic        rdy;
   logic        reset_from_rob_bus;
   logic [4:0]  rs1_from_issuer;
   logic [4:0]  rs2_from_issuer;
   logic [3:0]  qj_to_issuer;
   logic [31:0] vj_to_issuer;
   logic [3:0]  qk_to_issuer;
   logic [31:0] vk_to_issuer;
   logic        rename_valid_from_issuer;
   logic [4:0]  rd_from_issuer;
   logic [3:0]  dest_from_issuer;
   logic [3:0]  dest_from_rob;
   logic [4:0]  rd_from_rob;
   logic [31:0] value_from_rob;

   int vectors = 0;
   int errors  = 0;

   reg_file #(.REG_COUNT(32), .XLEN(32), .ROB_ID_W(4)) dut (
      .clk                      (clk),
      .rst                      (rst),
      .rdy                      (rdy),
      .reset_from_rob_bus       (reset_from_rob_bus),
      .rs1_from_issuer          (rs1_from_issuer),
      .rs2_from_issuer          (rs2_from_issuer),
      .qj_to_issuer             (qj_to_issuer),
      .vj_to_issuer             (vj_to_issuer),
      .qk_to_issuer             (qk_to_issuer),
      .vk_to_issuer             (vk_to_issuer),
      .rename_valid_from_issuer (rename_valid_from_issuer),
      .rd_from_issuer           (rd_from_issuer),
      .dest_from_issuer         (dest_from_issuer),
      .dest_from_rob            (dest_from_rob),
      .rd_from_rob              (rd_from_rob),
      .value_from_rob           (value_from_rob)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rdy                      = 1'b1;
      reset_from_rob_bus       = 1'b0;
      rename_valid_from_issuer = 1'b0;
      rd_from_issuer           = 5'd0;
      dest_from_issuer         = 4'd0;
      dest_from_rob            = 4'd0;
      rd_from_rob              = 5'd0;
      value_from_rob           = 32'd0;
   endtask

   task automatic rename(input logic [4:0] rd, input logic [3:0] id);
      rename_valid_from_issuer = 1'b1;
      rd_from_issuer           = rd;
      dest_from_issuer         = id;
   endtask

   task automatic commit(input logic [3:0] id, input logic [4:0] rd, input logic [31:0] val);
      dest_from_rob  = id;
      rd_from_rob    = rd;
      value_from_rob = val;
   endtask

   task automatic look(input logic [4:0] a, input logic [4:0] b);
      rs1_from_issuer = a;
      rs2_from_issuer = b;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      idle();
      commit(4'd1, 5'd5, 32'hAAAA_5555);
      look(5'd5, 5'd31);
      vectors++;
      if ({qj_to_issuer, vj_to_issuer} !== {4'd0, 32'd0}) begin
         $display("FAIL reset_rs1 got q=%0d v=%h want q=0 v=0", qj_to_issuer, vj_to_issuer);
         errors++;
      end
      vectors++;
      if ({qk_to_issuer, vk_to_issuer} !== {4'd0, 32'd0}) begin
         $display("FAIL reset_rs2 got q=%0d v=%h want q=0 v=0", qk_to_issuer, vk_to_issuer);
         errors++;
      end
      tick();
      idle();
      rst = 1'b1;
      tick();
   endtask

   task automatic test_plain_commit();
      idle();
      commit(4'd1, 5'd10, 32'h0000_1234);
      tick();
      idle();
      look(5'd10, 5'd0);
      vectors++;
      if ({qj_to_issuer, vj_to_issuer} !== {4'd0, 32'h0000_1234}) begin
         $display("FAIL plain_commit got q=%0d v=%h want q=0 v=00001234", qj_to_issuer, vj_to_issuer);
         errors++;
      end
      vectors++;
      if ({qk_to_issuer, vk_to_issuer} !== {4'd0, 32'd0}) begin
         $display("FAIL x0_lookup got q=%0d v=%h want q=0 v=0", qk_to_issuer, vk_to_issuer);
         errors++;
      end
   endtask

   task automatic test_rename_commit();
      idle();
      rename(5'd5, 4'd3);
      look(5'd5, 5'd5);
      vectors++;
      if (qj_to_issuer !== 4'd0) begin
         $display("FAIL rename_not_same_cycle got q=%0d want q=0", qj_to_issuer);
         errors++;
      end
      tick();
      idle();
      look(5'd5, 5'd5);
      vectors++;
      if (qj_to_issuer !== 4'd3) begin
         $display("FAIL rename_tag got q=%0d want q=3", qj_to_issuer);
         errors++;
      end
      commit(4'd3, 5'd5, 32'h0000_DEAD);
      #1;
      vectors++;
      if ({qj_to_issuer, vj_to_issuer} !== {4'd0, 32'h0000_DEAD}) begin
         $display("FAIL commit_bypass got q=%0d v=%h want q=0 v=0000dead", qj_to_issuer, vj_to_issuer);
         errors++;
      end
      tick();
      idle();
      look(5'd5, 5'd5);
      vectors++;
      if ({qk_to_issuer, vk_to_issuer} !== {4'd0, 32'h0000_DEAD}) begin
         $display("FAIL commit_cleared got q=%0d v=%h want q=0 v=0000dead", qk_to_issuer, vk_to_issuer);
         errors++;
      end
   endtask

   task automatic test_younger_producer();
      idle();
      rename(5'd7, 4'd2);
      tick();
      rename(5'd7, 4'd6);
      tick();
      idle();
      look(5'd7, 5'd0);
      vectors++;
      if (qj_to_issuer !== 4'd6) begin
         $display("FAIL younger_tag got q=%0d want q=6", qj_to_issuer);
         errors++;
      end
      commit(4'd2, 5'd7, 32'h0000_0011);
      #1;
      vectors++;
      if (qj_to_issuer !== 4'd6) begin
         $display("FAIL stale_no_bypass got q=%0d want q=6", qj_to_issuer);
         errors++;
      end
      tick();
      idle();
      look(5'd7, 5'd0);
      vectors++;
      if ({qj_to_issuer, vj_to_issuer} !== {4'd6, 32'h0000_0011}) begin
         $display("FAIL stale_commit got q=%0d v=%h want q=6 v=00000011", qj_to_issuer, vj_to_issuer);
         errors++;
      end
      commit(4'd6, 5'd7, 32'h0000_0022);
      tick();
      idle();
      look(5'd7, 5'd0);
      vectors++;
      if ({qj_to_issuer, vj_to_issuer} !== {4'd0, 32'h0000_0022}) begin
         $display("FAIL youngest_commit got q=%0d v=%h want q=0 v=00000022", qj_to_issuer, vj_to_issuer);
         errors++;
      end
   endtask

   task automatic test_back_to_back();
      idle();
      rename(5'd9, 4'd1);
      tick();
      rename(5'd9, 4'd4);
      commit(4'd1, 5'd9, 32'h0000_0055);
      tick();
      idle();
      look(5'd0, 5'd9);
      vectors++;
      if (qk_to_issuer !== 4'd4) begin
         $display("FAIL rename_wins_tag got q=%0d want q=4", qk_to_issuer);
         errors++;
      end
      reset_from_rob_bus = 1'b1;
      tick();
      idle();
      look(5'd0, 5'd9);
      vectors++;
      if ({qk_to_issuer, vk_to_issuer} !== {4'd0, 32'h0000_0055}) begin
         $display("FAIL commit_wins_value got q=%0d v=%h want q=0 v=00000055", qk_to_issuer, vk_to_issuer);
         errors++;
      end
   endtask

   task automatic test_flush();
      idle();
      rename(5'd1, 4'd1);
      tick();
      rename(5'd2, 4'd2);
      tick();
      rename(5'd3, 4'd3);
      tick();
      idle();
      look(5'd1, 5'd2);
      vectors++;
      if ({qj_to_issuer, qk_to_issuer} !== {4'd1, 4'd2}) begin
         $display("FAIL flush_pending got q=%0d/%0d want q=1/2", qj_to_issuer, qk_to_issuer);
         errors++;
      end
      reset_from_rob_bus = 1'b1;
      rename(5'd4, 4'd5);
      commit(4'd1, 5'd1, 32'h0000_0077);
      tick();
      idle();
      look(5'd1, 5'd2);
      vectors++;
      if ({qj_to_issuer, vj_to_issuer} !== {4'd0, 32'h0000_0077}) begin
         $display("FAIL flush_x1 got q=%0d v=%h want q=0 v=00000077", qj_to_issuer, vj_to_issuer);
         errors++;
      end
      vectors++;
      if ({qk_to_issuer, vk_to_issuer} !== {4'd0, 32'd0}) begin
         $display("FAIL flush_x2 got q=%0d v=%h want q=0 v=0", qk_to_issuer, vk_to_issuer);
         errors++;
      end
      look(5'd3, 5'd4);
      vectors++;
      if ({qj_to_issuer, qk_to_issuer} !== {4'd0, 4'd0}) begin
         $display("FAIL flush_x3_x4 got q=%0d/%0d want q=0/0", qj_to_issuer, qk_to_issuer);
         errors++;
      end
   endtask

   task automatic test_x0_and_rdy();
      idle();
      rename(5'd0, 4'd5);
      commit(4'd1, 5'd0, 32'h0000_00FF);
      look(5'd0, 5'd0);
      vectors++;
      if ({qj_to_issuer, vj_to_issuer} !== {4'd0, 32'd0}) begin
         $display("FAIL x0_same_cycle got q=%0d v=%h want q=0 v=0", qj_to_issuer, vj_to_issuer);
         errors++;
      end
      tick();
      idle();
      look(5'd0, 5'd0);
      vectors++;
      if ({qk_to_issuer, vk_to_issuer} !== {4'd0, 32'd0}) begin
         $display("FAIL x0_after got q=%0d v=%h want q=0 v=0", qk_to_issuer, vk_to_issuer);
         errors++;
      end
      rdy = 1'b0;
      rename(5'd12, 4'd5);
      commit(4'd1, 5'd10, 32'h0000_BEEF);
      tick();
      idle();
      look(5'd10, 5'd12);
      vectors++;
      if ({qj_to_issuer, vj_to_issuer} !== {4'd0, 32'h0000_1234}) begin
         $display("FAIL rdy0_commit got q=%0d v=%h want q=0 v=00001234", qj_to_issuer, vj_to_issuer);
         errors++;
      end
      vectors++;
      if (qk_to_issuer !== 4'd0) begin
         $display("FAIL rdy0_rename got q=%0d want q=0", qk_to_issuer);
         errors++;
      end
      rename(5'd13, 4'd2);
      tick();
      idle();
      rdy = 1'b0;
      reset_from_rob_bus = 1'b1;
      tick();
      idle();
      look(5'd13, 5'd0);
      vectors++;
      if (qj_to_issuer !== 4'd2) begin
         $display("FAIL rdy0_flush got q=%0d want q=2", qj_to_issuer);
         errors++;
      end
   endtask

   task automatic test_reset_midrun();
      idle();
      rst = 1'b0;
      look(5'd10, 5'd13);
      vectors++;
      if ({qj_to_issuer, vj_to_issuer, qk_to_issuer, vk_to_issuer} !== {4'd0, 32'd0, 4'd0, 32'd0}) begin
         $display("FAIL midrun_reset_held got q=%0d/%0d v=%h/%h want 0", qj_to_issuer, qk_to_issuer,
                  vj_to_issuer, vk_to_issuer);
         errors++;
      end
      tick();
      rst = 1'b1;
      tick();
      look(5'd10, 5'd13);
      vectors++;
      if ({qj_to_issuer, vj_to_issuer, qk_to_issuer, vk_to_issuer} !== {4'd0, 32'd0, 4'd0, 32'd0}) begin
         $display("FAIL midrun_reset_after got q=%0d/%0d v=%h/%h want 0", qj_to_issuer, qk_to_issuer,
                  vj_to_issuer, vk_to_issuer);
         errors++;
      end
   endtask

   initial begin
      rs1_from_issuer = 5'd0;
      rs2_from_issuer = 5'd0;
      test_reset();
      test_plain_commit();
      test_rename_commit();
      test_younger_producer();
      test_back_to_back();
      test_flush();
      test_x0_and_rdy();
      test_reset_midrun();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

`default_nettype wire
